// File: rtl/puf_buf_pkg.sv
// puf_buf_pkg
//   Shared definitions for the PUF/TRNG response buffer:
//   - puf_buf_state_e : fill controller states
//   - PUF_BUF_BYTE_WIDTH : bits per buffer entry (fixed at 8)
//   - puf_buf_depth() : byte depth derived from the address width
package puf_buf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_FULL = 2'd2
  } puf_buf_state_e;

  localparam int unsigned PUF_BUF_BYTE_WIDTH = 8;

  function automatic int unsigned puf_buf_depth(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

endpackage

// File: rtl/puf_buf_ram.sv
// puf_buf_ram
//   Simple dual-port RAM, one write port and one registered read port,
//   read-first on a same-address collision. The array has no reset so it
//   maps onto block RAM; only the read output register is cleared.
// Ports:
//   clk      : clock
//   reset    : synchronous active-high, clears the read output register
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   raddr_i  : read address, sampled every edge
//   rdata_o  : read data, one cycle after raddr_i
module puf_buf_ram
  import puf_buf_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 13,
  parameter int unsigned DATA_WIDTH = PUF_BUF_BYTE_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int unsigned DEPTH = puf_buf_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  // Non-blocking read of the array gives the pre-write byte on a collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= mem[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/puf_response_buffer.sv
// puf_response_buffer
//   Packs a serial PUF/TRNG bit stream MSB-first into bytes and fills a
//   2**ADDR_WIDTH byte buffer. A registered read port serves the consumer
//   in every state. fillStart (outside FILL) restarts a complete refill.
//
//   state | meaning
//   ------+------------------------------------------------
//   IDLE  | after reset, no fill started yet
//   FILL  | accepting bits, writing one byte per 8 bits
//   FULL  | every byte written, waiting for the next fillStart
//
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bitValid   : source bit available
//   bitData    : source bit value
//   bitReady   : bit accepted this cycle when bitValid is high (FILL only)
//   fillStart  : one-cycle refill request, ignored while filling
//   fillDone   : whole buffer written since the last accepted fillStart
//   fillCount  : bytes written in the current fill
//   rdAddr     : read byte address
//   rdData     : read data, one cycle latency
//
// Optional build macro PUF_BUF_VON_NEUMANN_EN: von Neumann debiasing of
// accepted bit pairs (01 -> 0, 10 -> 1, 00/11 dropped).
module puf_response_buffer
  import puf_buf_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 13,
  parameter int unsigned BYTE_WIDTH = PUF_BUF_BYTE_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  bitValid,
  input  logic                  bitData,
  output logic                  bitReady,
  input  logic                  fillStart,
  output logic                  fillDone,
  output logic [ADDR_WIDTH:0]   fillCount,
  input  logic [ADDR_WIDTH-1:0] rdAddr,
  output logic [BYTE_WIDTH-1:0] rdData
);

  localparam int unsigned DEPTH = puf_buf_depth(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [2:0] LAST_BIT = 3'(BYTE_WIDTH - 1);

  puf_buf_state_e        state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [BYTE_WIDTH-2:0] shift_q, shift_d;
  logic [ADDR_WIDTH:0]   fill_count_q, fill_count_d;
  logic                  fill_done_q, fill_done_d;

  logic                  accept;
  logic                  start_accept;
  logic                  out_valid;
  logic                  out_bit;
  logic                  byte_done;
  logic                  last_write;
  logic [BYTE_WIDTH-1:0] wr_data;

  assign bitReady     = (state_q == ST_FILL);
  assign accept       = bitValid && bitReady;
  assign start_accept = fillStart && (state_q != ST_FILL);

`ifdef PUF_BUF_VON_NEUMANN_EN
  logic pair_phase_q;
  logic pair_first_q;

  // Second bit of a pair emits the first bit if the two differ.
  assign out_valid = accept && pair_phase_q && (pair_first_q != bitData);
  assign out_bit   = pair_first_q;

  always_ff @(posedge clk) begin
    if (reset || start_accept) begin
      pair_phase_q <= 1'b0;
      pair_first_q <= 1'b0;
    end else if (accept) begin
      pair_phase_q <= ~pair_phase_q;
      if (!pair_phase_q) begin
        pair_first_q <= bitData;
      end
    end
  end
`else
  assign out_valid = accept;
  assign out_bit   = bitData;
`endif

  assign byte_done  = out_valid && (bit_cnt_q == LAST_BIT);
  assign last_write = byte_done && (wr_addr_q == LAST_ADDR);
  assign wr_data    = {shift_q, out_bit};

  always_comb begin
    state_d      = state_q;
    wr_addr_d    = wr_addr_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    fill_count_d = fill_count_q;
    fill_done_d  = fill_done_q;
    case (state_q)
      ST_IDLE, ST_FULL: begin
        if (fillStart) begin
          state_d      = ST_FILL;
          wr_addr_d    = '0;
          bit_cnt_d    = '0;
          shift_d      = '0;
          fill_count_d = '0;
          fill_done_d  = 1'b0;
        end
      end
      ST_FILL: begin
        if (out_valid) begin
          if (byte_done) begin
            shift_d      = '0;
            bit_cnt_d    = '0;
            wr_addr_d    = wr_addr_q + 1'b1;
            fill_count_d = fill_count_q + 1'b1;
            if (last_write) begin
              state_d     = ST_FULL;
              fill_done_d = 1'b1;
            end
          end else begin
            shift_d   = {shift_q[BYTE_WIDTH-3:0], out_bit};
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      wr_addr_q    <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      fill_count_q <= '0;
      fill_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_addr_q    <= wr_addr_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      fill_count_q <= fill_count_d;
      fill_done_q  <= fill_done_d;
    end
  end

  assign fillDone  = fill_done_q;
  assign fillCount = fill_count_q;

  puf_buf_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (BYTE_WIDTH)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .we_i    (byte_done),
    .waddr_i (wr_addr_q),
    .wdata_i (wr_data),
    .raddr_i (rdAddr),
    .rdata_o (rdData)
  );

endmodule

// File: tb/tb_puf_response_buffer.sv
// tb_puf_response_buffer
//   Directed bench for puf_response_buffer with ADDR_WIDTH = 4 (16 bytes).
//   Inputs change 1 time unit after the rising edge; outputs are sampled
//   at that same point, well away from the next edge.
module tb_puf_response_buffer;

  localparam int unsigned AW = 4;
  localparam int unsigned DEPTH = 16;

  logic          clk;
  logic          reset;
  logic          bitValid;
  logic          bitData;
  logic          bitReady;
  logic          fillStart;
  logic          fillDone;
  logic [AW:0]   fillCount;
  logic [AW-1:0] rdAddr;
  logic [7:0]    rdData;

  int n_checks;
  int n_errors;

  puf_response_buffer #(
    .ADDR_WIDTH (AW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bitValid  (bitValid),
    .bitData   (bitData),
    .bitReady  (bitReady),
    .fillStart (fillStart),
    .fillDone  (fillDone),
    .fillCount (fillCount),
    .rdAddr    (rdAddr),
    .rdData    (rdData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bitValid = 1'b1;
    bitData  = b;
    tick();
    bitValid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) begin
      send_bit(v[i]);
    end
  endtask

  task automatic pulse_start();
    fillStart = 1'b1;
    tick();
    fillStart = 1'b0;
  endtask

  task automatic read_chk(input string tag, input int addr, input int exp);
    rdAddr = AW'(addr);
    tick();
    check(tag, int'(rdData), exp);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    reset     = 1'b1;
    bitValid  = 1'b0;
    bitData   = 1'b0;
    fillStart = 1'b0;
    rdAddr    = '0;
    tick();
    tick();
    check("rst_bitReady", int'(bitReady), 0);
    check("rst_fillDone", int'(fillDone), 0);
    check("rst_fillCount", int'(fillCount), 0);
    check("rst_rdData", int'(rdData), 0);
    reset = 1'b0;
    tick();
    check("idle_bitReady", int'(bitReady), 0);

    // Basic fill with 0xA5.
    pulse_start();
    check("fill_bitReady", int'(bitReady), 1);
    for (int b = 0; b < DEPTH - 1; b++) send_byte(8'hA5);
    check("pre_last_fillDone", int'(fillDone), 0);
    check("pre_last_count", int'(fillCount), DEPTH - 1);
    send_byte(8'hA5);
    check("full_fillDone", int'(fillDone), 1);
    check("full_fillCount", int'(fillCount), DEPTH);
    check("full_bitReady", int'(bitReady), 0);
    for (int a = 0; a < DEPTH; a++) read_chk("read_A5", a, 8'hA5);

    // Refill with 0x3C, ignored restart and read/write collision.
    pulse_start();
    check("refill_fillDone", int'(fillDone), 0);
    check("refill_fillCount", int'(fillCount), 0);
    send_byte(8'h3C);
    send_byte(8'h3C);
    pulse_start();
    check("ignored_restart_count", int'(fillCount), 2);
    rdAddr = AW'(2);
    send_byte(8'h3C);
    check("collision_old", int'(rdData), 8'hA5);
    tick();
    check("collision_new", int'(rdData), 8'h3C);
    for (int b = 3; b < DEPTH; b++) send_byte(8'h3C);
    check("refill_done", int'(fillDone), 1);
    check("refill_count", int'(fillCount), DEPTH);
    for (int a = 0; a < DEPTH; a++) read_chk("read_3C", a, 8'h3C);

    // MSB-first packing.
    pulse_start();
    send_byte(8'h81);
    check("msb_count", int'(fillCount), 1);
    read_chk("msb_byte0", 0, 8'h81);

    // Reset mid-fill after 5 zero bits; partial byte must be dropped.
    for (int i = 0; i < 5; i++) send_bit(1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_bitReady", int'(bitReady), 0);
    check("midrst_fillDone", int'(fillDone), 0);
    check("midrst_fillCount", int'(fillCount), 0);
    check("midrst_rdData", int'(rdData), 0);
    read_chk("midrst_mem_kept", 5, 8'h3C);
    pulse_start();
    send_byte(8'hFF);
    check("midrst_count", int'(fillCount), 1);
    check("midrst_done", int'(fillDone), 0);
    read_chk("midrst_byte0", 0, 8'hFF);

`ifdef PUF_BUF_VON_NEUMANN_EN
    // Pairs 00,11,10,01 repeated: only 10 -> 1 and 01 -> 0 produce bits.
    pulse_start();
    for (int r = 0; r < 4; r++) begin
      send_bit(1'b0); send_bit(1'b0);
      send_bit(1'b1); send_bit(1'b1);
      send_bit(1'b1); send_bit(1'b0);
      if (r == 3) check("vn_count_before_last", int'(fillCount), 0);
      send_bit(1'b0); send_bit(1'b1);
    end
    check("vn_count", int'(fillCount), 1);
    read_chk("vn_byte0", 0, 8'hAA);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
